// File: rtl/qcldpc_cw_serializer_if.sv
// Stream interfaces around the QC-LDPC codeword serializer: a whole-codeword
// input stream and a per-Z-block output stream, each with a valid/ready handshake.
interface qcldpc_cw_if #(
    parameter int MAX_Z = 81,
    parameter int NBLK  = 24,
    parameter int NUM_Z = 3
);
    logic [MAX_Z*NBLK-1:0] data;
    logic [NUM_Z-1:0]      z_sel;
    logic                  valid;
    logic                  ready;

    modport master (output data, output z_sel, output valid, input  ready);
    modport slave  (input  data, input  z_sel, input  valid, output ready);
endinterface

interface qcldpc_blk_if #(
    parameter int MAX_Z = 81,
    parameter int IW    = 5,
    parameter int NUM_Z = 3
);
    logic [MAX_Z-1:0] data;
    logic [IW-1:0]    blk_idx;
    logic             is_parity;
    logic [NUM_Z-1:0] z_sel;
    logic             sop;
    logic             eop;
    logic             valid;
    logic             ready;

    modport master (output data, output blk_idx, output is_parity, output z_sel,
                    output sop, output eop, output valid, input ready);
    modport slave  (input  data, input  blk_idx, input  is_parity, input  z_sel,
                    input  sop, input  eop, input  valid, output ready);
endinterface

// File: rtl/qcldpc_cw_serializer.sv
// Two-bank ping-pong codeword buffer that streams one Z-masked block per cycle.
// Define QCLDPC_SER_PARITY_ONLY_EN to emit only the parity blocks.
module qcldpc_cw_serializer #(
    parameter int MAX_Z            = 81,
    parameter int NUM_INFO_BLKS    = 20,
    parameter int NUM_PARITY_BLKS  = 4,
    parameter int NUM_Z            = 3,
    parameter int Z_VALUES [NUM_Z] = '{27, 54, 81},
    localparam int NBLK            = NUM_INFO_BLKS + NUM_PARITY_BLKS,
    localparam int IW              = $clog2(NBLK)
) (
    input  logic         CLK,
    input  logic         rst_n,
    qcldpc_cw_if.slave   cw,
    qcldpc_blk_if.master blk,
    output logic         err_zsel
);

`ifdef QCLDPC_SER_PARITY_ONLY_EN
    localparam logic [IW-1:0] START_IDX = IW'(NUM_INFO_BLKS);
`else
    localparam logic [IW-1:0] START_IDX = '0;
`endif
    localparam logic [IW-1:0] LAST_IDX   = IW'(NBLK - 1);
    localparam logic [IW-1:0] PARITY_IDX = IW'(NUM_INFO_BLKS);

    function automatic logic [MAX_Z-1:0] z_mask(input int z);
        logic [MAX_Z-1:0] m;
        for (int b = 0; b < MAX_Z; b++) begin
            m[b] = (b < z);
        end
        return m;
    endfunction

    // Bank storage carries no reset; only the flags and pointers do.
    logic [MAX_Z-1:0] bank_mem      [2][NBLK];
    logic [NUM_Z-1:0] bank_zsel_mem [2];

    logic [1:0]    full_reg, full_next;
    logic          wr_bank_reg, wr_bank_next;
    logic          rd_bank_reg, rd_bank_next;
    logic [IW-1:0] blk_idx_reg, blk_idx_next;
    logic          err_reg, err_next;

    logic zsel_onehot;
    logic accept;
    logic out_valid;
    logic fire;
    logic last_blk;

    assign zsel_onehot = (cw.z_sel != '0) && ((cw.z_sel & (cw.z_sel - NUM_Z'(1))) == '0);
    assign cw.ready    = !full_reg[wr_bank_reg];
    assign accept      = cw.valid && cw.ready;
    assign out_valid   = full_reg[rd_bank_reg];
    assign fire        = out_valid && blk.ready;
    assign last_blk    = (blk_idx_reg == LAST_IDX);

    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        blk_idx_next = blk_idx_reg;
        err_next     = err_reg;
        // Accept and final drain always target different banks, so both may apply.
        if (accept) begin
            if (zsel_onehot) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = ~wr_bank_reg;
            end else begin
                err_next = 1'b1;
            end
        end
        if (fire) begin
            if (last_blk) begin
                blk_idx_next           = START_IDX;
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = ~rd_bank_reg;
            end else begin
                blk_idx_next = blk_idx_reg + IW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            blk_idx_reg <= START_IDX;
            err_reg     <= 1'b0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            blk_idx_reg <= blk_idx_next;
            err_reg     <= err_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && zsel_onehot) begin
            bank_zsel_mem[wr_bank_reg] <= cw.z_sel;
            for (int k = 0; k < NBLK; k++) begin
                bank_mem[wr_bank_reg][k] <= cw.data[k*MAX_Z +: MAX_Z];
            end
        end
    end

    logic [NUM_Z-1:0] rd_zsel;
    logic [MAX_Z-1:0] zterm [NUM_Z];
    logic [MAX_Z-1:0] rd_mask;
    logic [MAX_Z-1:0] rd_word;

    assign rd_zsel = bank_zsel_mem[rd_bank_reg];
    assign rd_word = bank_mem[rd_bank_reg][blk_idx_reg];

    generate
        for (genvar gi = 0; gi < NUM_Z; gi++) begin : g_zmask
            localparam logic [MAX_Z-1:0] ZM = z_mask(Z_VALUES[gi]);
            assign zterm[gi] = rd_zsel[gi] ? ZM : '0;
        end
    endgenerate

    always_comb begin
        rd_mask = '0;
        for (int k = 0; k < NUM_Z; k++) begin
            rd_mask = rd_mask | zterm[k];
        end
    end

    // Every output is gated by out_valid so idle/reset values are all zero.
    assign blk.valid     = out_valid;
    assign blk.data      = out_valid ? (rd_word & rd_mask) : '0;
    assign blk.blk_idx   = out_valid ? blk_idx_reg : '0;
    assign blk.is_parity = out_valid && (blk_idx_reg >= PARITY_IDX);
    assign blk.sop       = out_valid && (blk_idx_reg == START_IDX);
    assign blk.eop       = out_valid && last_blk;
    assign blk.z_sel     = out_valid ? rd_zsel : '0;
    assign err_zsel      = err_reg;

endmodule
